// File: rtl/map_cfg_seq_pkg.sv
// Shared definitions for the mapper config sequencer: mapper indices, register map,
// CTRL/STATUS bit positions and the sequencer state encoding.
package map_cfg_seq_pkg;

    localparam logic [7:0] MAP_NOM = 8'd0;
    localparam logic [7:0] MAP_SMD = 8'd1;
    localparam logic [7:0] MAP_CDB = 8'd2;
    localparam logic [7:0] MAP_10M = 8'd3;

    localparam logic [1:0] REG_MAP_IDX = 2'd0;
    localparam logic [1:0] REG_FLAGS   = 2'd1;
    localparam logic [1:0] REG_CTRL    = 2'd2;
    localparam logic [1:0] REG_STATUS  = 2'd3;

    localparam int CTRL_COMMIT = 0;
    localparam int CTRL_RUN    = 1;
    localparam int CTRL_CLR    = 2;

    localparam int STAT_BUSY = 7;
    localparam int STAT_ERR  = 6;
    localparam int STAT_OVR  = 5;

    typedef enum logic [2:0] {
        CS_IDLE   = 3'd0,
        CS_HOLD   = 3'd1,
        CS_SWAP   = 3'd2,
        CS_MRST   = 3'd3,
        CS_SETTLE = 3'd4
    } cfg_seq_state_e;

    function automatic logic [7:0] status_word(input logic       busy,
                                               input logic       err,
                                               input logic       ovr,
                                               input logic [2:0] st);
        logic [7:0] w;
        w            = 8'h00;
        w[STAT_BUSY] = busy;
        w[STAT_ERR]  = err;
        w[STAT_OVR]  = ovr;
        w[2:0]       = st;
        return w;
    endfunction

endpackage

// File: rtl/map_cfg_seq_cyc_timer.sv
// Loadable down-counter that saturates at zero; done is high while the count is zero.
module cyc_timer #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             run,
    output logic             done
);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (run && (cnt_q != '0)) begin
            cnt_d = cnt_q - WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign done = (cnt_q == '0);

endmodule

// File: rtl/map_cfg_seq.sv
// Mapper config sequencer: MCU shadow registers plus the FSM that swaps the live
// mapper config only while the console is held in reset and its bus has gone idle.
module map_cfg_seq
    import map_cfg_seq_pkg::*;
#(
    parameter int IDLE_CYC   = 8,
    parameter int TOUT_CYC   = 4096,
    parameter int MRST_CYC   = 16,
    parameter int SETTLE_CYC = 64
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       reg_we,
    input  logic [1:0] reg_addr,
    input  logic [7:0] reg_di,
    output logic [7:0] reg_do,
    input  logic       bus_as_n,
    output logic [7:0] cfg_map_idx,
    output logic [7:0] cfg_flags,
    output logic       map_rst,
    output logic       cons_rst,
    output logic       busy
);

    localparam int IDLE_W   = $clog2(IDLE_CYC) + 1;
    localparam int TOUT_W   = $clog2(TOUT_CYC) + 1;
    localparam int MRST_W   = $clog2(MRST_CYC) + 1;
    localparam int SETTLE_W = $clog2(SETTLE_CYC) + 1;

    // Timers are loaded with N-1 so that done marks the last cycle of an N-cycle window.
    localparam logic [IDLE_W-1:0]   IDLE_LD   = IDLE_W'(IDLE_CYC - 1);
    localparam logic [TOUT_W-1:0]   TOUT_LD   = TOUT_W'(TOUT_CYC - 1);
    localparam logic [MRST_W-1:0]   MRST_LD   = MRST_W'(MRST_CYC - 1);
    localparam logic [SETTLE_W-1:0] SETTLE_LD = SETTLE_W'(SETTLE_CYC - 1);

    cfg_seq_state_e state_q, state_d;
    logic [7:0]     shadow_idx_q, shadow_idx_d;
    logic [7:0]     shadow_flags_q, shadow_flags_d;
    logic [7:0]     cfg_idx_q, cfg_idx_d;
    logic [7:0]     cfg_flags_q, cfg_flags_d;
    logic           err_q, err_d;
    logic           ovr_q, ovr_d;
    logic           run_q, run_d;
    logic           cons_rst_q, cons_rst_d;
    logic           map_rst_q, map_rst_d;

    logic idle_load, idle_run, idle_done;
    logic tout_load, tout_run, tout_done;
    logic mrst_load, mrst_run, mrst_done;
    logic settle_load, settle_run, settle_done;

    logic wr_ctrl;
    logic commit_req;
    logic clr_req;

    assign wr_ctrl    = reg_we && (reg_addr == REG_CTRL);
    assign commit_req = wr_ctrl && reg_di[CTRL_COMMIT];
    assign clr_req    = wr_ctrl && reg_di[CTRL_CLR];

    cyc_timer #(.WIDTH(IDLE_W)) u_idle_tmr (
        .clk      (clk),
        .rst      (rst),
        .load     (idle_load),
        .load_val (IDLE_LD),
        .run      (idle_run),
        .done     (idle_done)
    );

    cyc_timer #(.WIDTH(TOUT_W)) u_tout_tmr (
        .clk      (clk),
        .rst      (rst),
        .load     (tout_load),
        .load_val (TOUT_LD),
        .run      (tout_run),
        .done     (tout_done)
    );

    cyc_timer #(.WIDTH(MRST_W)) u_mrst_tmr (
        .clk      (clk),
        .rst      (rst),
        .load     (mrst_load),
        .load_val (MRST_LD),
        .run      (mrst_run),
        .done     (mrst_done)
    );

    cyc_timer #(.WIDTH(SETTLE_W)) u_settle_tmr (
        .clk      (clk),
        .rst      (rst),
        .load     (settle_load),
        .load_val (SETTLE_LD),
        .run      (settle_run),
        .done     (settle_done)
    );

    always_comb begin
        state_d        = state_q;
        shadow_idx_d   = shadow_idx_q;
        shadow_flags_d = shadow_flags_q;
        cfg_idx_d      = cfg_idx_q;
        cfg_flags_d    = cfg_flags_q;
        err_d          = err_q;
        ovr_d          = ovr_q;
        run_d          = run_q;
        cons_rst_d     = cons_rst_q;
        idle_load      = 1'b0;
        idle_run       = 1'b0;
        tout_load      = 1'b0;
        tout_run       = 1'b0;
        mrst_load      = 1'b0;
        mrst_run       = 1'b0;
        settle_load    = 1'b0;
        settle_run     = 1'b0;

        if (reg_we && (reg_addr == REG_MAP_IDX)) begin
            shadow_idx_d = reg_di;
        end
        if (reg_we && (reg_addr == REG_FLAGS)) begin
            shadow_flags_d = reg_di;
        end

        // A new error event in the same cycle as a clear wins over the clear.
        if (clr_req) begin
            err_d = 1'b0;
            ovr_d = 1'b0;
        end
        if (commit_req && (state_q != CS_IDLE)) begin
            ovr_d = 1'b1;
        end

        case (state_q)
            CS_IDLE: begin
                if (commit_req) begin
                    state_d    = CS_HOLD;
                    run_d      = reg_di[CTRL_RUN];
                    cons_rst_d = 1'b1;
                    idle_load  = 1'b1;
                    tout_load  = 1'b1;
                end
            end
            CS_HOLD: begin
                tout_run = 1'b1;
                if (bus_as_n) begin
                    idle_run = 1'b1;
                end else begin
                    idle_load = 1'b1;
                end
                if (bus_as_n && idle_done) begin
                    state_d   = CS_SWAP;
                    mrst_load = 1'b1;
                end else if (tout_done) begin
                    state_d   = CS_SWAP;
                    err_d     = 1'b1;
                    mrst_load = 1'b1;
                end
            end
            CS_SWAP: begin
                // Registered shadows only: a write landing in this cycle misses the swap.
                cfg_idx_d   = shadow_idx_q;
                cfg_flags_d = shadow_flags_q;
                mrst_run    = 1'b1;
                state_d     = CS_MRST;
            end
            CS_MRST: begin
                mrst_run = 1'b1;
                if (mrst_done) begin
                    state_d     = CS_SETTLE;
                    settle_load = 1'b1;
                end
            end
            CS_SETTLE: begin
                settle_run = 1'b1;
                if (settle_done) begin
                    state_d    = CS_IDLE;
                    cons_rst_d = ~run_q;
                end
            end
            default: begin
                state_d = CS_IDLE;
            end
        endcase

        map_rst_d = (state_d == CS_SWAP) || (state_d == CS_MRST);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= CS_IDLE;
            shadow_idx_q   <= 8'h00;
            shadow_flags_q <= 8'h00;
            cfg_idx_q      <= MAP_NOM;
            cfg_flags_q    <= 8'h00;
            err_q          <= 1'b0;
            ovr_q          <= 1'b0;
            run_q          <= 1'b0;
            cons_rst_q     <= 1'b1;
            map_rst_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            shadow_idx_q   <= shadow_idx_d;
            shadow_flags_q <= shadow_flags_d;
            cfg_idx_q      <= cfg_idx_d;
            cfg_flags_q    <= cfg_flags_d;
            err_q          <= err_d;
            ovr_q          <= ovr_d;
            run_q          <= run_d;
            cons_rst_q     <= cons_rst_d;
            map_rst_q      <= map_rst_d;
        end
    end

    assign busy        = (state_q != CS_IDLE);
    assign cfg_map_idx = cfg_idx_q;
    assign cfg_flags   = cfg_flags_q;
    assign map_rst     = map_rst_q;
    assign cons_rst    = cons_rst_q;

    always_comb begin
        case (reg_addr)
            REG_MAP_IDX: reg_do = shadow_idx_q;
            REG_FLAGS:   reg_do = shadow_flags_q;
            REG_STATUS:  reg_do = status_word(busy, err_q, ovr_q, state_q);
            default:     reg_do = 8'h00;
        endcase
    end

endmodule
